csa42_accum: RTL and testbench
==============================

Name: csa42_accum

Overview:
- Streaming multi-operand accumulator built from two cascaded 4:2 carry-save stages.
- Absorbs four DW-bit operands per accepted beat into a redundant (sum, carry) state with no carry propagation in the loop.
- On the last beat of a frame, resolves the state through one carry-propagate add and presents the AW-bit total on a valid/ready output.
- Sits behind dot-product and checksum datapaths that need high-rate reduction with a single resolve per frame.

Parameters:
- DW, 16, operand width.
- AW, 24, accumulator/result width; must satisfy AW >= DW+2.

Ports:
- clk  input  1  clock, all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush: zero the accumulator, drop any pending result.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_last  input  1  qualifies the final beat of a frame.
- in0  input  DW  operand 0.
- in1  input  DW  operand 1.
- in2  input  DW  operand 2.
- in3  input  DW  operand 3.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  AW  frame total, modulo 2^AW.

Behaviour:
- Reset (nreset low, asynchronous):
  - state=ACC.
  - S=0, C=0, out_sum=0, out_valid=0.
  - in_ready=1 once the state is ACC.
- Beat acceptance: accept = in_valid & in_ready. in_ready = (state==ACC). No combinational path from out_ready to in_ready.
- Arithmetic on accept:
  - Zero-extend in0..in3 to AW.
  - Stage A: 4:2 compress in0..in3 to (sa, ca).
  - Stage B: 4:2 compress S, C, sa, ca to (S', C').
  - Carries shift left one bit; bits at or above AW are discarded (modulo 2^AW).
  - Internal compressor carry-in is 0.
  - Invariant: S+C (mod 2^AW) equals the sum of all operands accepted since the last clear, flush or result handoff.
- FSM states: ACC, RES, OUT.
  - ACC: each accept updates S,C. If accept & in_last, go to RES; otherwise stay in ACC.
  - RES: single cycle. in_ready=0. out_sum <= S+C (AW-bit CPA, carry-out dropped). out_valid <= 1. Go to OUT.
  - OUT: out_valid=1; out_sum is held stable while out_valid & ~out_ready. in_ready=0.
  - OUT handoff: on out_valid & out_ready, out_valid<=0, S<=0, C<=0, go to ACC. The next beat can be accepted the cycle after the handoff.
- Latency: last beat accepted at edge t; out_valid is high after edge t+1.
- Single-beat frame (in_last on the first beat): same latency; total = in0+in1+in2+in3.
- in_valid low in ACC: S,C hold.
- in_last is ignored when in_valid=0.
- clear (highest priority after reset), effective from any state:
  - S=0, C=0, out_valid=0, state=ACC.
  - out_sum keeps its last value.
  - A beat presented in the same cycle is not accumulated.
- Overflow: silent wrap modulo 2^AW, no flag.
- Reset mid-frame: partial accumulation is lost; no result is produced.

Optional Feature:
- Macro: CSA42_ACCUM_BEATCNT_EN.
- When defined:
  - Adds output out_beats [15:0] = number of beats accepted in the frame, including the last.
  - Registered with out_sum in RES and held through OUT.
  - Internal counter resets to 0 on reset, clear and handoff, and saturates at 16'hFFFF.
  - out_beats resets to 0.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Single beat 1,2,3,4 with in_last=1 at cycle 0, out_ready=1 -> out_valid high after edge 1, out_sum=10; out_beats=1 if enabled.
- Three beats of all 16'hFFFF, last on beat 3 -> out_sum=24'h0BFFF4 (12×65535); in_ready low for exactly the RES and OUT cycles.
- AW=18, DW=16, eight beats of 16'hFFFF -> out_sum = (32×65535) mod 2^18 = 18'h3FFE0 (wrap checked).
- out_ready held low 5 cycles in OUT -> out_sum stable, in_valid beats not accepted; handoff on cycle 6, beat accepted on cycle 7.
- clear asserted mid-frame after two beats, then beat 5,5,5,5 with in_last -> out_sum=20; clear asserted in OUT -> out_valid drops the next cycle and no handoff occurs.
- nreset pulsed low asynchronously mid-frame -> out_valid=0 and out_sum=0 immediately; the next frame 1,1,1,1 with in_last -> out_sum=4.

Source files
------------

// File: rtl/csa42_accum.sv
// csa42_accum: streaming four-operand accumulator.
// Each accepted beat is folded into a redundant (sum, carry) state through two
// cascaded 4:2 carry-save stages, so the loop has no carry propagation. On the
// last beat of a frame the state is resolved once by a carry-propagate add and
// offered on a valid/ready output port.
// Optional feature macro: CSA42_ACCUM_BEATCNT_EN adds out_beats, the number of
// beats accepted in the frame (saturating at 16'hFFFF).
module csa42_accum #(
  parameter int DW = 16,
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [DW-1:0] in0,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  input  logic [DW-1:0] in3,
  output logic          out_valid,
  input  logic          out_ready,
`ifdef CSA42_ACCUM_BEATCNT_EN
  output logic [15:0]   out_beats,
`endif
  output logic [AW-1:0] out_sum
);

  localparam logic [1:0] ST_ACC = 2'd0;
  localparam logic [1:0] ST_RES = 2'd1;
  localparam logic [1:0] ST_OUT = 2'd2;

  // Bitwise majority of three vectors (full-adder carry before the shift).
  function automatic logic [AW-1:0] maj3(input logic [AW-1:0] a,
                                         input logic [AW-1:0] b,
                                         input logic [AW-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // 4:2 compressor built from two 3:2 layers with zero carry-in; returns
  // {sum, carry}. Carries are shifted left and bits above AW are dropped.
  function automatic logic [2*AW-1:0] csa42(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic [AW-1:0] c,
                                            input logic [AW-1:0] d);
    logic [AW-1:0] s1;
    logic [AW-1:0] m1;
    logic [AW-1:0] c1;
    logic [AW-1:0] s2;
    logic [AW-1:0] m2;
    logic [AW-1:0] c2;
    s1 = a ^ b ^ c;
    m1 = maj3(a, b, c);
    c1 = {m1[AW-2:0], 1'b0};
    s2 = s1 ^ c1 ^ d;
    m2 = maj3(s1, c1, d);
    c2 = {m2[AW-2:0], 1'b0};
    return {s2, c2};
  endfunction

  logic [1:0]      state_q, state_d;
  logic [AW-1:0]   s_q, s_d;
  logic [AW-1:0]   c_q, c_d;
  logic [AW-1:0]   sum_q, sum_d;
  logic            valid_q, valid_d;
  logic            accept_s;
  logic [2*AW-1:0] stage_a_s;
  logic [2*AW-1:0] stage_b_s;
`ifdef CSA42_ACCUM_BEATCNT_EN
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     beats_q, beats_d;
`endif

  assign in_ready  = (state_q == ST_ACC);
  assign accept_s  = in_valid & in_ready;
  assign out_valid = valid_q;
  assign out_sum   = sum_q;
`ifdef CSA42_ACCUM_BEATCNT_EN
  assign out_beats = beats_q;
`endif

  // Two-stage carry-save reduction: operands first, then merge with state.
  always_comb begin
    stage_a_s = csa42({{(AW-DW){1'b0}}, in0}, {{(AW-DW){1'b0}}, in1},
                      {{(AW-DW){1'b0}}, in2}, {{(AW-DW){1'b0}}, in3});
    stage_b_s = csa42(s_q, c_q, stage_a_s[2*AW-1:AW], stage_a_s[AW-1:0]);
  end

  // Next-state logic: clear overrides everything, then the ACC/RES/OUT FSM.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    sum_d   = sum_q;
    valid_d = valid_q;
`ifdef CSA42_ACCUM_BEATCNT_EN
    cnt_d   = cnt_q;
    beats_d = beats_q;
`endif
    if (clear) begin
      // Flush: result register keeps its last value, pending result is dropped.
      state_d = ST_ACC;
      s_d     = {AW{1'b0}};
      c_d     = {AW{1'b0}};
      valid_d = 1'b0;
`ifdef CSA42_ACCUM_BEATCNT_EN
      cnt_d   = 16'd0;
`endif
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept_s) begin
            s_d = stage_b_s[2*AW-1:AW];
            c_d = stage_b_s[AW-1:0];
`ifdef CSA42_ACCUM_BEATCNT_EN
            if (cnt_q != 16'hFFFF) begin
              cnt_d = cnt_q + 16'd1;
            end else begin
              cnt_d = cnt_q;
            end
`endif
            if (in_last) begin
              state_d = ST_RES;
            end else begin
              state_d = ST_ACC;
            end
          end else begin
            state_d = ST_ACC;
          end
        end
        ST_RES: begin
          // Single carry-propagate resolve per frame; carry-out is dropped.
          sum_d   = s_q + c_q;
          valid_d = 1'b1;
          state_d = ST_OUT;
`ifdef CSA42_ACCUM_BEATCNT_EN
          beats_d = cnt_q;
`endif
        end
        ST_OUT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            s_d     = {AW{1'b0}};
            c_d     = {AW{1'b0}};
            state_d = ST_ACC;
`ifdef CSA42_ACCUM_BEATCNT_EN
            cnt_d   = 16'd0;
`endif
          end else begin
            state_d = ST_OUT;
          end
        end
        default: begin
          state_d = ST_ACC;
          valid_d = 1'b0;
          s_d     = {AW{1'b0}};
          c_d     = {AW{1'b0}};
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_ACC;
      s_q     <= {AW{1'b0}};
      c_q     <= {AW{1'b0}};
      sum_q   <= {AW{1'b0}};
      valid_q <= 1'b0;
`ifdef CSA42_ACCUM_BEATCNT_EN
      cnt_q   <= 16'd0;
      beats_q <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
`ifdef CSA42_ACCUM_BEATCNT_EN
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa42_accum.sv
// Directed testbench for csa42_accum (AW=24 instance plus an AW=18 instance
// sharing the same stimulus for the wrap-around case).
module tb_csa42_accum;

  logic        clk;
  logic        nreset;
  logic        clear;
  logic        in_valid;
  logic        in_last;
  logic [15:0] in0, in1, in2, in3;
  logic        out_ready;
  logic        in_ready, out_valid;
  logic [23:0] out_sum;
  logic        in_ready18, out_valid18;
  logic [17:0] out_sum18;
`ifdef CSA42_ACCUM_BEATCNT_EN
  logic [15:0] out_beats;
  logic [15:0] out_beats18;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  csa42_accum #(.DW(16), .AW(24)) dut (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef CSA42_ACCUM_BEATCNT_EN
    .out_beats(out_beats),
`endif
    .out_sum(out_sum)
  );

  csa42_accum #(.DW(16), .AW(18)) dut18 (
    .clk(clk), .nreset(nreset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready18), .in_last(in_last),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_valid(out_valid18), .out_ready(out_ready),
`ifdef CSA42_ACCUM_BEATCNT_EN
    .out_beats(out_beats18),
`endif
    .out_sum(out_sum18)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d,
                       input logic last);
    in_valid = 1'b1;
    in0 = a; in1 = b; in2 = c; in3 = d;
    in_last = last;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in0 = 16'd0; in1 = 16'd0; in2 = 16'd0; in3 = 16'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0; clear = 1'b0; out_ready = 1'b0;
    idle();
    #2;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    n_checks++;
    if (out_sum !== 24'd0) begin n_fail++; $display("FAIL reset_sum got %h exp 0", out_sum); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", in_ready); end
`ifdef CSA42_ACCUM_BEATCNT_EN
    n_checks++;
    if (out_beats !== 16'd0) begin n_fail++; $display("FAIL reset_beats got %0d exp 0", out_beats); end
`endif
    #10;
    nreset = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(16'd1, 16'd2, 16'd3, 16'd4, 1'b1);
    step();
    idle();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_res got rdy=%b vld=%b exp rdy=0 vld=0", in_ready, out_valid);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd10) begin
      n_fail++; $display("FAIL single_out got vld=%b sum=%0d exp vld=1 sum=10", out_valid, out_sum);
    end
`ifdef CSA42_ACCUM_BEATCNT_EN
    n_checks++;
    if (out_beats !== 16'd1) begin n_fail++; $display("FAIL single_beats got %0d exp 1", out_beats); end
`endif
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_handoff got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ffff();
    out_ready = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ffff_mid_ready got %b exp 1", in_ready); end
    step();
    in_last = 1'b1;
    step();
    idle();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ffff_res_ready got %b exp 0", in_ready); end
    step();
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 24'h0BFFF4) begin
      n_fail++; $display("FAIL ffff_out got rdy=%b vld=%b sum=%h exp rdy=0 vld=1 sum=0bfff4", in_ready, out_valid, out_sum);
    end
`ifdef CSA42_ACCUM_BEATCNT_EN
    n_checks++;
    if (out_beats !== 16'd3) begin n_fail++; $display("FAIL ffff_beats got %0d exp 3", out_beats); end
`endif
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL ffff_after got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    drive(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    for (int i = 0; i < 7; i++) step();
    in_last = 1'b1;
    step();
    idle();
    step();
    n_checks++;
    if (out_valid18 !== 1'b1 || out_sum18 !== 18'h3FFE0) begin
      n_fail++; $display("FAIL wrap18 got vld=%b sum=%h exp vld=1 sum=3ffe0", out_valid18, out_sum18);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'h1FFFE0) begin
      n_fail++; $display("FAIL wrap24 got vld=%b sum=%h exp vld=1 sum=1fffe0", out_valid, out_sum);
    end
`ifdef CSA42_ACCUM_BEATCNT_EN
    n_checks++;
    if (out_beats !== 16'd8) begin n_fail++; $display("FAIL wrap_beats got %0d exp 8", out_beats); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(16'd7, 16'd0, 16'd0, 16'd0, 1'b1);
    step();
    idle();
    step();
    // Beats offered while the result waits must not be taken.
    drive(16'd100, 16'd0, 16'd0, 16'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 24'd7 || in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d] got vld=%b sum=%0d rdy=%b exp vld=1 sum=7 rdy=0", i, out_valid, out_sum, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_handoff got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
    step();
    idle();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept got rdy=%b exp 0", in_ready); end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd100) begin
      n_fail++; $display("FAIL bp_next got vld=%b sum=%0d exp vld=1 sum=100", out_valid, out_sum);
    end
    step();
  endtask

  task automatic test_clear();
    out_ready = 1'b0;
    drive(16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    step();
    step();
    clear = 1'b1;
    drive(16'd9, 16'd9, 16'd9, 16'd9, 1'b1);
    step();
    clear = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clear_mid got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    drive(16'd5, 16'd5, 16'd5, 16'd5, 1'b1);
    step();
    idle();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd20) begin
      n_fail++; $display("FAIL clear_frame got vld=%b sum=%0d exp vld=1 sum=20", out_valid, out_sum);
    end
`ifdef CSA42_ACCUM_BEATCNT_EN
    n_checks++;
    if (out_beats !== 16'd1) begin n_fail++; $display("FAIL clear_beats got %0d exp 1", out_beats); end
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 24'd20) begin
      n_fail++; $display("FAIL clear_out got vld=%b rdy=%b sum=%0d exp vld=0 rdy=1 sum=20", out_valid, in_ready, out_sum);
    end
    out_ready = 1'b1;
    drive(16'd2, 16'd0, 16'd0, 16'd0, 1'b1);
    step();
    idle();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd2) begin
      n_fail++; $display("FAIL clear_fresh got vld=%b sum=%0d exp vld=1 sum=2", out_valid, out_sum);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    drive(16'd3, 16'd3, 16'd3, 16'd3, 1'b0);
    step();
    step();
    idle();
    #2;
    nreset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_sum !== 24'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async got vld=%b sum=%0d rdy=%b exp vld=0 sum=0 rdy=1", out_valid, out_sum, in_ready);
    end
    #2;
    nreset = 1'b1;
    step();
    drive(16'd1, 16'd1, 16'd1, 16'd1, 1'b1);
    step();
    idle();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== 24'd4) begin
      n_fail++; $display("FAIL rstmid_frame got vld=%b sum=%0d exp vld=1 sum=4", out_valid, out_sum);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_handoff got vld=%b exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ffff();
    test_wrap();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
